// File: rtl/elmnt_wise_mult_window.sv
// Sliding N_REG-tap window times per-tap Q(WIDTH-FBITS).FBITS weights, saturated, packed per lane.
// Latency: one cycle from the accept that completes the window to out_valid/out_multiply.
// Backpressure: a held vector (out_valid && !out_ready) blocks input; clear also blocks input.
module elmnt_wise_mult_window #(
    parameter int WIDTH = 32,
    parameter int FBITS = 24,
    parameter int N_REG = 31
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       w_load,
    input  logic [$clog2(N_REG)-1:0]   w_idx,
    input  logic [WIDTH-1:0]           w_data,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           x_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_REG*WIDTH-1:0]     out_multiply
);

    localparam int FW = $clog2(N_REG + 1);

    typedef logic signed [WIDTH-1:0]   word_t;
    typedef logic signed [2*WIDTH-1:0] dword_t;

    localparam dword_t SAT_HI = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam dword_t SAT_LO = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam word_t  WORD_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam word_t  WORD_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    word_t                   win_q     [N_REG];
    word_t                   win_d     [N_REG];
    word_t                   weight_q  [N_REG];
    word_t                   weight_d  [N_REG];
    word_t                   nwin      [N_REG];
    word_t                   prod_sat  [N_REG];
    logic [FW-1:0]           fill_q;
    logic [FW-1:0]           fill_d;
    logic [FW-1:0]           fill_inc;
    logic                    out_valid_q;
    logic                    out_valid_d;
    logic [N_REG*WIDTH-1:0]  out_multiply_q;
    logic [N_REG*WIDTH-1:0]  out_multiply_d;
    logic                    accept;

    assign in_ready     = !clear && (!out_valid_q || out_ready);
    assign accept       = in_valid && in_ready;
    assign out_valid    = out_valid_q;
    assign out_multiply = out_multiply_q;
    assign fill_inc     = (fill_q == FW'(N_REG)) ? fill_q : fill_q + FW'(1);

    // Products use the post-shift window so the sample accepted this edge lands in lane 0.
    assign nwin[0] = x_in;
    for (genvar i = 1; i < N_REG; i++) begin : g_nwin
        assign nwin[i] = win_q[i-1];
    end

    for (genvar i = 0; i < N_REG; i++) begin : g_lane
        dword_t full_prod;
        dword_t shr_prod;
        word_t  lane_res;

        always_comb begin
            full_prod = $signed({{WIDTH{nwin[i][WIDTH-1]}}, nwin[i]})
                      * $signed({{WIDTH{weight_q[i][WIDTH-1]}}, weight_q[i]});
            // Arithmetic shift floors toward minus infinity before clamping.
            shr_prod  = full_prod >>> FBITS;
            if (shr_prod > SAT_HI) begin
                lane_res = WORD_MAX;
            end else if (shr_prod < SAT_LO) begin
                lane_res = WORD_MIN;
            end else begin
                lane_res = shr_prod[WIDTH-1:0];
            end
        end

        assign prod_sat[i] = lane_res;
    end

    always_comb begin
        win_d          = win_q;
        weight_d       = weight_q;
        fill_d         = fill_q;
        out_valid_d    = out_valid_q;
        out_multiply_d = out_multiply_q;

        if (clear) begin
            for (int i = 0; i < N_REG; i++) begin
                win_d[i] = '0;
            end
            fill_d      = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            win_d  = nwin;
            fill_d = fill_inc;
            if (fill_inc == FW'(N_REG)) begin
                for (int i = 0; i < N_REG; i++) begin
                    out_multiply_d[i*WIDTH +: WIDTH] = prod_sat[i];
                end
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // Weight writes are independent of clear/accept; an accept this edge saw the old weight.
        if (w_load && (32'(w_idx) < N_REG)) begin
            weight_d[w_idx] = w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q          <= '{default: '0};
            weight_q       <= '{default: '0};
            fill_q         <= '0;
            out_valid_q    <= 1'b0;
            out_multiply_q <= '0;
        end else begin
            win_q          <= win_d;
            weight_q       <= weight_d;
            fill_q         <= fill_d;
            out_valid_q    <= out_valid_d;
            out_multiply_q <= out_multiply_d;
        end
    end

endmodule

// File: tb/tb_elmnt_wise_mult_window.sv
// Bench for elmnt_wise_mult_window at N_REG=4: directed scenarios then random traffic against a queue-based model.
module tb_elmnt_wise_mult_window;

    localparam int W  = 32;
    localparam int FB = 24;
    localparam int N  = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
    localparam logic [31:0] ONE = 32'h0100_0000;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           w_load;
    logic [1:0]     w_idx;
    logic [W-1:0]   w_data;
    logic           clear;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   x_in;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_multiply;

    int checks   = 0;
    int failures = 0;

    logic [31:0]    win_m [$];
    logic [31:0]    wt_m  [N];
    logic [N*W-1:0] out_m;
    logic           vld_m;

    always #5 clk = ~clk;

    elmnt_wise_mult_window #(.WIDTH(W), .FBITS(FB), .N_REG(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_load       (w_load),
        .w_idx        (w_idx),
        .w_data       (w_data),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .x_in         (x_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_multiply (out_multiply)
    );

    function automatic logic [31:0] mul_ref(input logic [31:0] x, input logic [31:0] w);
        longint p;
        p = longint'($signed(x)) * longint'($signed(w));
        p = p >>> FB;
        if (p > SMAX) return 32'h7FFF_FFFF;
        if (p < SMIN) return 32'h8000_0000;
        return p[31:0];
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic acc;
        if (!rst_n) begin
            win_m.delete();
            for (int i = 0; i < N; i++) wt_m[i] = '0;
            out_m = '0;
            vld_m = 1'b0;
            return;
        end
        acc = in_valid && !clear && (!vld_m || out_ready);
        if (clear) begin
            win_m.delete();
            vld_m = 1'b0;
        end else if (acc) begin
            win_m.push_front(x_in);
            if (win_m.size() > N) void'(win_m.pop_back());
            if (win_m.size() == N) begin
                for (int i = 0; i < N; i++) out_m[i*W +: W] = mul_ref(win_m[i], wt_m[i]);
                vld_m = 1'b1;
            end else begin
                vld_m = 1'b0;
            end
        end else if (vld_m && out_ready) begin
            vld_m = 1'b0;
        end
        if (w_load) wt_m[w_idx] = w_data;
    endtask

    task automatic cyc(input string tag);
        #1;
        check({tag, ".in_ready"}, in_ready, !clear && (!vld_m || out_ready));
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".out_valid"}, out_valid, vld_m);
        check({tag, ".out_multiply"}, out_multiply, out_m);
    endtask

    task automatic drive(input string tag, input logic v, input logic [31:0] x, input logic ordy,
                         input logic clr, input logic wl, input logic [1:0] wi, input logic [31:0] wd);
        in_valid  = v;
        x_in      = x;
        out_ready = ordy;
        clear     = clr;
        w_load    = wl;
        w_idx     = wi;
        w_data    = wd;
        cyc(tag);
    endtask

    task automatic push(input string tag, input logic [31:0] x);
        drive(tag, 1'b1, x, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic wload(input logic [1:0] idx, input logic [31:0] d);
        drive("wload", 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, idx, d);
    endtask

    initial begin
        logic [31:0] r;
        rst_n = 1'b0; w_load = 1'b0; w_idx = '0; w_data = '0; clear = 1'b0;
        in_valid = 1'b0; x_in = '0; out_ready = 1'b1;

        @(posedge clk);
        model_edge();
        #1;
        check("reset.out_valid", out_valid, 1'b0);
        check("reset.out_multiply", out_multiply, 128'd0);
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) wload(2'(i), ONE);

        // Priming: vector appears only with the 4th accept.
        for (int i = 0; i < 3; i++) push("prime", 32'h0080_0000);
        check("prime.low_after3", out_valid, 1'b0);
        push("prime", 32'h0080_0000);
        check("prime.valid_after4", out_valid, 1'b1);
        check("prime.lanes", out_multiply, {4{32'h0080_0000}});

        // Sliding window of raw integers.
        drive("clr", 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        for (int i = 1; i <= 4; i++) push("slide", 32'(i));
        check("slide.after4", out_multiply, 128'h00000001_00000002_00000003_00000004);
        push("slide", 32'd5);
        check("slide.after5_valid", out_valid, 1'b1);
        check("slide.after5", out_multiply, 128'h00000002_00000003_00000004_00000005);

        // Saturation and flooring.
        wload(2'd0, 32'h7FFF_FFFF);
        wload(2'd1, 32'h7FFF_FFFF);
        wload(2'd2, 32'h0080_0000);
        push("arith", 32'd5);
        push("arith", 32'hFFFF_FFFF);
        push("arith", 32'h8000_0000);
        push("arith", 32'h7FFF_FFFF);
        check("arith.lanes", out_multiply, 128'h00000005_FFFFFFFF_80000000_7FFFFFFF);

        // Backpressure hold.
        for (int i = 0; i < 5; i++) begin
            drive("bp", 1'b1, $urandom, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
            check("bp.in_ready", in_ready, 1'b0);
            check("bp.hold", out_multiply, 128'h00000005_FFFFFFFF_80000000_7FFFFFFF);
        end
        drive("bp_release", 1'b1, 32'h0000_0009, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        check("bp.release_valid", out_valid, 1'b1);

        // Clear mid-priming restarts the fill count.
        for (int i = 0; i < 3; i++) wload(2'(i), ONE);
        drive("clr", 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        push("clrprime", 32'd20);
        push("clrprime", 32'd21);
        drive("clr", 1'b1, 32'd22, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        for (int i = 10; i <= 12; i++) push("clrprime", 32'(i));
        check("clr.low_after3", out_valid, 1'b0);
        push("clrprime", 32'd13);
        check("clr.valid_after4", out_valid, 1'b1);

        // Weight write on the same edge as an accept.
        drive("wl_same", 1'b1, 32'd7, 1'b1, 1'b0, 1'b1, 2'd1, 32'h0200_0000);
        check("wl_same.old_weight", out_multiply, 128'h0000000B_0000000C_0000000D_00000007);
        push("wl_next", 32'd8);
        check("wl_next.new_weight", out_multiply, 128'h0000000C_0000000D_0000000E_00000008);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            drive("rand", $urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? $urandom : {{16{r[15]}}, r[15:0]},
                  $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? $urandom : {{7{r[24]}}, r[24:0]});
        end

        // Reset while a vector is valid.
        for (int i = 0; i < 4; i++) push("pre_rst", $urandom);
        check("pre_rst.valid", out_valid, 1'b1);
        rst_n = 1'b0;
        drive("rst", 1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        rst_n = 1'b1;
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.out_multiply", out_multiply, 128'd0);
        out_ready = 1'b1;
        #1;
        check("rst.in_ready", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) push("post_rst", $urandom);
        check("post_rst.zero_products", out_multiply, 128'd0);
        wload(2'd0, ONE);
        push("post_rst_w", 32'h0000_0030);
        check("post_rst.lane0", out_multiply[31:0], 32'h0000_0030);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
